// File: rtl/uart_pkg.sv
// Shared types for the UART host bridge: byte type and the TX/RX handshake state encodings.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Labels carry a TX_/RX_ prefix so both enums can live in one package scope.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ACK,
    RX_WAIT_LOW
  } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through output; DEPTH must be a power of two.
// Push when full and pop when empty are ignored; pointers wrap naturally.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_host_bridge.sv
// Host-side bridge for the UART core: TX/RX FIFOs plus the load and acknowledge handshakes.
// Optional macro UART_HOST_ECHO_EN adds echo_mode, looping received bytes back into the TX FIFO.
module uart_host_bridge
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             uart_wr_enb,
  output logic [7:0]       uart_data_in,
  input  logic             uart_tx_active,
  input  logic             uart_rx_ready,
  input  logic [7:0]       uart_rx_data,
  output logic             uart_rdy_clr,
  output logic [LVL_W-1:0] tx_level,
  output logic [LVL_W-1:0] rx_level,
  output logic             rx_overflow,
`ifdef UART_HOST_ECHO_EN
  input  logic             echo_mode,
`endif
  input  logic             ovf_clr
);

  tx_state_t tx_state_q, tx_state_d;
  rx_state_t rx_state_q, rx_state_d;
  byte_t     tx_head, tx_din, data_in_q;
  logic      tx_full, tx_empty, rx_full, rx_empty;
  logic      tx_push, tx_pop, rx_push, rx_pop, ack, ovf_q;

  assign ack = (rx_state_q == RX_ACK);

`ifdef UART_HOST_ECHO_EN
  logic echo_push;
  // Echo owns the TX FIFO write port during ACK, so the host is stalled that cycle.
  assign echo_push = ack & echo_mode & ~rx_full;
  assign tx_ready  = ~tx_full & ~ack;
  assign tx_push   = echo_push | (tx_valid & tx_ready);
  assign tx_din    = echo_push ? uart_rx_data : tx_data;
`else
  assign tx_ready  = ~tx_full;
  assign tx_push   = tx_valid & tx_ready;
  assign tx_din    = tx_data;
`endif

  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_valid & rx_ready;

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(tx_din),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(uart_rx_data),
    .dout(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      data_in_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      if (tx_state_q == TX_LOAD) data_in_q <= tx_head;
      if (ack && rx_full)        ovf_q     <= 1'b1;
      else if (ovf_clr)          ovf_q     <= 1'b0;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE:      if (!tx_empty && !uart_tx_active) tx_state_d = TX_LOAD;
      TX_LOAD:      tx_state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (uart_tx_active) tx_state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!uart_tx_active) tx_state_d = TX_IDLE;
      default:      tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:     if (uart_rx_ready) rx_state_d = RX_ACK;
      RX_ACK:      rx_state_d = RX_WAIT_LOW;
      RX_WAIT_LOW: if (!uart_rx_ready) rx_state_d = RX_IDLE;
      default:     rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    uart_wr_enb  = (tx_state_q == TX_LOAD);
    tx_pop       = (tx_state_q == TX_LOAD);
    uart_rdy_clr = ack;
    rx_push      = ack;
  end

  // Head is shown combinationally in LOAD, then held by the register until the next load.
  assign uart_data_in = uart_wr_enb ? tx_head : data_in_q;
  assign rx_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed self-checking bench for uart_host_bridge with a behavioural transmitter busy model.
module tb_uart_host_bridge;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tx_valid = 1'b0;
  logic [7:0]       tx_data = '0;
  logic             tx_ready;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready = 1'b0;
  logic             uart_wr_enb;
  logic [7:0]       uart_data_in;
  logic             uart_tx_active;
  logic             uart_rx_ready = 1'b0;
  logic [7:0]       uart_rx_data = '0;
  logic             uart_rdy_clr;
  logic [LVL_W-1:0] tx_level;
  logic [LVL_W-1:0] rx_level;
  logic             rx_overflow;
  logic             ovf_clr = 1'b0;
`ifdef UART_HOST_ECHO_EN
  logic             echo_mode = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  int         busy_cnt = 0;
  int         busy_len = 3;
  logic       force_busy = 1'b0;
  int         busy_viol = 0;
  int         clr_cnt = 0;
  logic [7:0] tx_log[$];

  always #5 clk = ~clk;

  assign uart_tx_active = (busy_cnt != 0) | force_busy;

  uart_host_bridge #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .uart_wr_enb(uart_wr_enb), .uart_data_in(uart_data_in),
    .uart_tx_active(uart_tx_active), .uart_rx_ready(uart_rx_ready),
    .uart_rx_data(uart_rx_data), .uart_rdy_clr(uart_rdy_clr),
    .tx_level(tx_level), .rx_level(rx_level), .rx_overflow(rx_overflow),
`ifdef UART_HOST_ECHO_EN
    .echo_mode(echo_mode),
`endif
    .ovf_clr(ovf_clr)
  );

  // Transmitter model: a load makes it busy for busy_len cycles; loads while busy are logged as violations.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt <= 0;
    end else if (uart_wr_enb) begin
      if (uart_tx_active) busy_viol <= busy_viol + 1;
      tx_log.push_back(uart_data_in);
      busy_cnt <= busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (uart_rdy_clr) clr_cnt <= clr_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    uart_rx_ready = 1'b1;
    uart_rx_data  = d;
    tick(3);
    uart_rx_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++;
    if ({tx_ready, rx_valid, uart_wr_enb, uart_rdy_clr, rx_overflow} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 10000", {tx_ready, rx_valid, uart_wr_enb, uart_rdy_clr, rx_overflow});
    end
    checks++;
    if (uart_data_in !== 8'h00 || tx_level !== '0 || rx_level !== '0) begin
      failures++;
      $display("FAIL reset_values: data_in=%h tx_level=%0d rx_level=%0d expected 00/0/0", uart_data_in, tx_level, rx_level);
    end
  endtask

  task automatic test_single_tx;
    busy_len = 3;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tick(1);
    tx_valid = 1'b0;
    checks++;
    if (uart_wr_enb !== 1'b0 || tx_level !== LVL_W'(1)) begin
      failures++;
      $display("FAIL single_queued: wr_enb=%b tx_level=%0d expected 0/1", uart_wr_enb, tx_level);
    end
    tick(1);
    checks++;
    if (uart_wr_enb !== 1'b1 || uart_data_in !== 8'hA5) begin
      failures++;
      $display("FAIL single_load: wr_enb=%b data_in=%h expected 1/a5", uart_wr_enb, uart_data_in);
    end
    tick(1);
    checks++;
    if (uart_wr_enb !== 1'b0 || tx_level !== '0 || uart_data_in !== 8'hA5) begin
      failures++;
      $display("FAIL single_after: wr_enb=%b tx_level=%0d data_in=%h expected 0/0/a5", uart_wr_enb, tx_level, uart_data_in);
    end
    tick(10);
  endtask

  task automatic test_back_to_back;
    int base, viol0, t;
    logic [7:0] exp_b;
    busy_len = 100;
    base  = tx_log.size();
    viol0 = busy_viol;
    for (int i = 1; i <= 3; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(i);
      tick(1);
    end
    tx_valid = 1'b0;
    t = 0;
    while (!(tx_log.size() >= base + 3 && tx_level == '0 && !uart_tx_active) && t < 1500) begin
      tick(1);
      t++;
    end
    tick(5);
    checks++;
    if (t >= 1500 || tx_log.size() !== base + 3) begin
      failures++;
      $display("FAIL b2b_count: loads=%0d expected 3 (waited %0d cycles)", tx_log.size() - base, t);
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_b = 8'(i + 1);
        checks++;
        if (tx_log[base + i] !== exp_b) begin
          failures++;
          $display("FAIL b2b_order[%0d]: got %h expected %h", i, tx_log[base + i], exp_b);
        end
      end
    end
    checks++;
    if (busy_viol !== viol0) begin
      failures++;
      $display("FAIL b2b_busy: loads while busy=%0d expected 0", busy_viol - viol0);
    end
    busy_len = 3;
  endtask

  task automatic test_rx_single;
    int base;
    base = clr_cnt;
    uart_rx_ready = 1'b1;
    uart_rx_data  = 8'h3C;
    tick(5);
    uart_rx_ready = 1'b0;
    tick(3);
    checks++;
    if (clr_cnt - base !== 1) begin
      failures++;
      $display("FAIL rx_single_ack: rdy_clr pulses=%0d expected 1", clr_cnt - base);
    end
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C || rx_level !== LVL_W'(1)) begin
      failures++;
      $display("FAIL rx_single_data: valid=%b data=%h level=%0d expected 1/3c/1", rx_valid, rx_data, rx_level);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0 || rx_level !== '0) begin
      failures++;
      $display("FAIL rx_single_pop: valid=%b level=%0d expected 0/0", rx_valid, rx_level);
    end
  endtask

  task automatic test_rx_overflow;
    int base;
    logic [7:0] exp_b;
    for (int i = 0; i < DEPTH; i++) rx_byte(8'(8'h10 + i));
    checks++;
    if (rx_level !== LVL_W'(DEPTH) || rx_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_fill: level=%0d ovf=%b expected 16/0", rx_level, rx_overflow);
    end
    base = clr_cnt;
    rx_byte(8'hEE);
    checks++;
    if (clr_cnt - base !== 1 || rx_overflow !== 1'b1 || rx_level !== LVL_W'(DEPTH) || rx_data !== 8'h10) begin
      failures++;
      $display("FAIL ovf_drop: pulses=%0d ovf=%b level=%0d head=%h expected 1/1/16/10", clr_cnt - base, rx_overflow, rx_level, rx_data);
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: ovf=%b expected 0", rx_overflow);
    end
    // Drop and clear in the same cycle: the set must win.
    uart_rx_ready = 1'b1;
    uart_rx_data  = 8'hEF;
    tick(1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    checks++;
    if (rx_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_wins: ovf=%b expected 1", rx_overflow);
    end
    uart_rx_ready = 1'b0;
    tick(2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    rx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = 8'(8'h10 + i);
      checks++;
      if (rx_data !== exp_b) begin
        failures++;
        $display("FAIL ovf_drain[%0d]: got %h expected %h", i, rx_data, exp_b);
      end
      tick(1);
    end
    rx_ready = 1'b0;
    checks++;
    if (rx_level !== '0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_empty: level=%0d valid=%b expected 0/0", rx_level, rx_valid);
    end
  endtask

  task automatic test_tx_full_pop;
    int base, t;
    busy_len   = 3;
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(8'hB0 + i);
      tick(1);
    end
    tx_valid = 1'b0;
    checks++;
    if (tx_level !== LVL_W'(DEPTH) || tx_ready !== 1'b0 || uart_wr_enb !== 1'b0) begin
      failures++;
      $display("FAIL full_fill: level=%0d ready=%b wr_enb=%b expected 16/0/0", tx_level, tx_ready, uart_wr_enb);
    end
    base = tx_log.size();
    force_busy = 1'b0;
    tick(1);
    checks++;
    if (uart_wr_enb !== 1'b1 || uart_data_in !== 8'hB0 || tx_level !== LVL_W'(DEPTH) || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_load: wr_enb=%b data=%h level=%0d ready=%b expected 1/b0/16/0", uart_wr_enb, uart_data_in, tx_level, tx_ready);
    end
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    tick(1);
    tx_valid = 1'b0;
    checks++;
    if (tx_level !== LVL_W'(DEPTH - 1) || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop: level=%0d ready=%b expected 15/1", tx_level, tx_ready);
    end
    t = 0;
    while (!(tx_log.size() >= base + DEPTH && tx_level == '0 && !uart_tx_active) && t < 2000) begin
      tick(1);
      t++;
    end
    tick(5);
    checks++;
    if (t >= 2000 || tx_log.size() !== base + DEPTH) begin
      failures++;
      $display("FAIL full_drain: loads=%0d expected 16 (waited %0d cycles)", tx_log.size() - base, t);
    end else begin
      checks++;
      if (tx_log[base + DEPTH - 1] !== 8'hBF) begin
        failures++;
        $display("FAIL full_last: got %h expected bf", tx_log[base + DEPTH - 1]);
      end
    end
  endtask

  task automatic test_reset_flush;
    force_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(8'hC0 + i);
      tick(1);
    end
    tx_valid = 1'b0;
    rx_byte(8'h42);
    checks++;
    if (tx_level !== LVL_W'(3) || rx_level !== LVL_W'(1)) begin
      failures++;
      $display("FAIL flush_pre: tx_level=%0d rx_level=%0d expected 3/1", tx_level, rx_level);
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    force_busy = 1'b0;
    tick(1);
    checks++;
    if (tx_level !== '0 || rx_level !== '0 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_post: tx_level=%0d rx_level=%0d ready=%b valid=%b expected 0/0/1/0", tx_level, rx_level, tx_ready, rx_valid);
    end
    tick(3);
  endtask

`ifdef UART_HOST_ECHO_EN
  task automatic test_echo;
    int base, t;
    echo_mode = 1'b1;
    base = tx_log.size();
    uart_rx_ready = 1'b1;
    uart_rx_data  = 8'h55;
    tick(1);
    checks++;
    if (uart_rdy_clr !== 1'b1 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL echo_ack: rdy_clr=%b tx_ready=%b expected 1/0", uart_rdy_clr, tx_ready);
    end
    tick(2);
    uart_rx_ready = 1'b0;
    t = 0;
    while (tx_log.size() < base + 1 && t < 200) begin
      tick(1);
      t++;
    end
    tick(10);
    checks++;
    if (tx_log.size() !== base + 1) begin
      failures++;
      $display("FAIL echo_count: loads=%0d expected 1", tx_log.size() - base);
    end else begin
      checks++;
      if (tx_log[base] !== 8'h55) begin
        failures++;
        $display("FAIL echo_data: got %h expected 55", tx_log[base]);
      end
    end
    checks++;
    if (rx_data !== 8'h55 || rx_level !== LVL_W'(1)) begin
      failures++;
      $display("FAIL echo_rx: data=%h level=%0d expected 55/1", rx_data, rx_level);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    echo_mode = 1'b0;
    tick(2);
  endtask
`endif

  initial begin
    test_reset();
    test_single_tx();
    test_back_to_back();
    test_rx_single();
    test_rx_overflow();
    test_tx_full_pop();
    test_reset_flush();
`ifdef UART_HOST_ECHO_EN
    test_echo();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
